reg_wr_arb: RTL and testbench

REG_WR_ARB -- requirements
Module: reg_wr_arb

---
 rtl/reg_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 37 +++
 rtl/reg_wr_arb.sv | 125 ++++++++++++
 tb/tb_reg_wr_arb.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - shared constants and state type for the shared-register write arbiter
package reg_arb_pkg;

  // Default requester count and matching source-index width.
  localparam int NREQ_DEFAULT = 4;
  localparam int SRC_W        = $clog2(NREQ_DEFAULT);

  // Arbiter states; LOCKED is only reachable when REG_ARB_LOCK_EN is defined.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner selection
// Ports:
//   req   [NREQ-1:0]  request vector, bit k = requester k
//   ptr   [SW-1:0]    highest-priority requester index
//   gnt   [NREQ-1:0]  one-hot winner (zero when no request)
//   index [SW-1:0]    winner index (zero when no request)
//   any               at least one request present
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int SW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [SW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [SW-1:0]   index,
  output logic            any
);

  logic [SW-1:0] cand;

  // Walk the search order backwards so the candidate closest to ptr is
  // written last and therefore wins. NREQ is a power of two, so the SW-bit
  // addition wraps modulo NREQ for free.
  always_comb begin
    index = '0;
    cand  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = ptr + SW'(i);
      if (req[cand]) index = cand;
    end
    any = |req;
    gnt = any ? (NREQ'(1) << index) : '0;
  end

endmodule

// File: rtl/reg_wr_arb.sv
// rtl/reg_wr_arb.sv - round-robin arbitrated writes into one shared register
// Optional feature macro: REG_ARB_LOCK_EN (owner lock via i_lock).
// Ports:
//   clk                    rising-edge clock
//   i_rst                  asynchronous active-high reset
//   i_sclr                 synchronous clear
//   i_req   [NREQ-1:0]     write requests
//   i_data  [NREQ*WIDTH]   packed write data, requester k at [k*WIDTH +: WIDTH]
//   i_lock  [NREQ-1:0]     lock requests (ignored unless REG_ARB_LOCK_EN)
//   o_gnt   [NREQ-1:0]     registered one-hot grant / ack
//   o_src   [SRC_W-1:0]    index of last granted requester
//   o_valid                o_y was written at the previous edge
//   o_y     [WIDTH-1:0]    shared register
module reg_wr_arb
  import reg_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = NREQ_DEFAULT
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_sclr,
  input  logic [NREQ-1:0]          i_req,
  input  logic [NREQ*WIDTH-1:0]    i_data,
  input  logic [NREQ-1:0]          i_lock,
  output logic [NREQ-1:0]          o_gnt,
  output logic [$clog2(NREQ)-1:0]  o_src,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_y
);

  localparam int SW = $clog2(NREQ);

  logic [SW-1:0]    ptr;
  logic [WIDTH-1:0] data_arr [NREQ];
  logic [NREQ-1:0]  arb_req;
  logic [NREQ-1:0]  pick_gnt;
  logic [SW-1:0]    pick_idx;
  logic             pick_any;
  logic             grant_now;
  logic [SW-1:0]    sel;
  logic [NREQ-1:0]  next_gnt;

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign data_arr[k] = i_data[k*WIDTH +: WIDTH];
  end

`ifdef REG_ARB_LOCK_EN
  arb_state_e state;
  logic       hold;

  // While LOCKED, o_src is the owner. The owner keeps the register as long as
  // it holds both req and lock; once it lets go, the same edge arbitrates
  // among everyone else starting at owner+1 (ptr already points there).
  always_comb begin
    hold    = (state == LOCKED) && i_req[o_src] && i_lock[o_src];
    arb_req = (state == LOCKED) ? (i_req & ~(NREQ'(1) << o_src)) : i_req;
  end
`else
  logic unused_lock;
  assign unused_lock = ^i_lock;
  assign arb_req     = i_req;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .SW   (SW)
  ) u_pick (
    .req   (arb_req),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .index (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
`ifdef REG_ARB_LOCK_EN
    grant_now = hold | pick_any;
    sel       = hold ? o_src : pick_idx;
    next_gnt  = hold ? (NREQ'(1) << o_src) : pick_gnt;
`else
    grant_now = pick_any;
    sel       = pick_idx;
    next_gnt  = pick_gnt;
`endif
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      o_y     <= '0;
      o_gnt   <= '0;
      o_src   <= '0;
      o_valid <= 1'b0;
      ptr     <= '0;
`ifdef REG_ARB_LOCK_EN
      state   <= IDLE;
`endif
    end else if (i_sclr) begin
      o_y     <= '0;
      o_gnt   <= '0;
      o_src   <= '0;
      o_valid <= 1'b0;
      ptr     <= '0;
`ifdef REG_ARB_LOCK_EN
      state   <= IDLE;
`endif
    end else if (grant_now) begin
      o_y     <= data_arr[sel];
      o_gnt   <= next_gnt;
      o_src   <= sel;
      o_valid <= 1'b1;
      ptr     <= sel + SW'(1);
`ifdef REG_ARB_LOCK_EN
      state   <= i_lock[sel] ? LOCKED : IDLE;
`endif
    end else begin
      o_gnt   <= '0;
      o_valid <= 1'b0;
`ifdef REG_ARB_LOCK_EN
      state   <= IDLE;
`endif
    end
  end

endmodule

// File: tb/tb_reg_wr_arb.sv
// tb/tb_reg_wr_arb.sv - directed self-checking bench for reg_wr_arb
module tb_reg_wr_arb;
  import reg_arb_pkg::*;

  logic              clk = 1'b0;
  logic              i_rst;
  logic              i_sclr;
  logic [3:0]        i_req;
  logic [127:0]      i_data;
  logic [3:0]        i_lock;
  logic [3:0]        o_gnt;
  logic [SRC_W-1:0]  o_src;
  logic              o_valid;
  logic [31:0]       o_y;
  logic [31:0]       d [4];

  int checks   = 0;
  int failures = 0;

  assign i_data = {d[3], d[2], d[1], d[0]};

  always #5 clk = ~clk;

  reg_wr_arb #(
    .WIDTH (32),
    .NREQ  (4)
  ) dut (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_sclr  (i_sclr),
    .i_req   (i_req),
    .i_data  (i_data),
    .i_lock  (i_lock),
    .o_gnt   (o_gnt),
    .o_src   (o_src),
    .o_valid (o_valid),
    .o_y     (o_y)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] gnt, input logic [1:0] src,
                         input logic valid, input logic [31:0] y);
    chk({tag, "_gnt"}, 64'(o_gnt), 64'(gnt));
    chk({tag, "_src"}, 64'(o_src), 64'(src));
    chk({tag, "_valid"}, 64'(o_valid), 64'(valid));
    chk({tag, "_y"}, 64'(o_y), 64'(y));
  endtask

  initial begin
    i_rst  = 1'b0;
    i_sclr = 1'b0;
    i_req  = 4'b0000;
    i_lock = 4'b0000;
    d[0]   = 32'h1111_0000;
    d[1]   = 32'h2222_0001;
    d[2]   = 32'h0000_00A5;
    d[3]   = 32'h4444_0003;
    #1 i_rst = 1'b1;
    tick();
    chk_out("reset", 4'b0000, 2'd0, 1'b0, 32'h0);
    i_rst = 1'b0;

    // Single write from requester 2, then idle.
    i_req = 4'b0100;
    tick();
    chk_out("single", 4'b0100, 2'd2, 1'b1, 32'h0000_00A5);
    i_req = 4'b0000;
    tick();
    chk_out("single_after", 4'b0000, 2'd2, 1'b0, 32'h0000_00A5);

    // Sync clear beats a simultaneous request and zeroes ptr.
    i_sclr = 1'b1;
    i_req  = 4'b0010;
    tick();
    chk_out("sclr", 4'b0000, 2'd0, 1'b0, 32'h0);
    i_sclr = 1'b0;
    i_req  = 4'b1001;
    tick();
    chk_out("sclr_next", 4'b0001, 2'd0, 1'b1, 32'h1111_0000);

    // Clear ptr again, then all four request for five edges.
    i_sclr = 1'b1;
    i_req  = 4'b0000;
    tick();
    i_sclr = 1'b0;
    i_req  = 4'b1111;
    tick();
    chk_out("rr0", 4'b0001, 2'd0, 1'b1, 32'h1111_0000);
    tick();
    chk_out("rr1", 4'b0010, 2'd1, 1'b1, 32'h2222_0001);
    tick();
    chk_out("rr2", 4'b0100, 2'd2, 1'b1, 32'h0000_00A5);
    tick();
    chk_out("rr3", 4'b1000, 2'd3, 1'b1, 32'h4444_0003);
    tick();
    chk_out("rr_wrap", 4'b0001, 2'd0, 1'b1, 32'h1111_0000);

    // Grant 0x12345678 from requester 1, then four idle cycles hold it.
    d[1]  = 32'h1234_5678;
    i_req = 4'b0010;
    tick();
    chk_out("hold_wr", 4'b0010, 2'd1, 1'b1, 32'h1234_5678);
    i_req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("idle_hold", 4'b0000, 2'd1, 1'b0, 32'h1234_5678);
    end

    // Lock scenario: req0+lock0 for three edges with req1 also held.
    i_sclr = 1'b1;
    tick();
    i_sclr = 1'b0;
    i_req  = 4'b0011;
    i_lock = 4'b0001;
`ifdef REG_ARB_LOCK_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("lock_own", 4'b0001, 2'd0, 1'b1, 32'h1111_0000);
    end
    i_lock = 4'b0000;
    tick();
    chk_out("lock_release", 4'b0010, 2'd1, 1'b1, 32'h1234_5678);
`else
    tick();
    chk_out("nolock_a", 4'b0001, 2'd0, 1'b1, 32'h1111_0000);
    tick();
    chk_out("nolock_b", 4'b0010, 2'd1, 1'b1, 32'h1234_5678);
    tick();
    chk_out("nolock_c", 4'b0001, 2'd0, 1'b1, 32'h1111_0000);
    i_lock = 4'b0000;
    tick();
    chk_out("nolock_d", 4'b0010, 2'd1, 1'b1, 32'h1234_5678);
`endif

    // Asynchronous reset in the middle of a grant cycle.
    i_req = 4'b1111;
    tick();
    chk("pre_rst_valid", 64'(o_valid), 64'd1);
    #3 i_rst = 1'b1;
    #1;
    chk_out("async_rst", 4'b0000, 2'd0, 1'b0, 32'h0);
    #1 i_rst = 1'b0;
    tick();
    chk_out("post_rst", 4'b0001, 2'd0, 1'b1, 32'h1111_0000);
    i_req = 4'b0000;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
